// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, instruction-cache geometry, frame layout and FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ITAG_W        = 26;
  localparam int IIDX_W        = 4;
  localparam int ICACHE_FRAMES = 16;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 16 one-word frames, zero-cycle
// hit lookup, and a single outstanding miss fetched from the memory controller.
module icache
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  icache_frame_t             frames_q [ICACHE_FRAMES];
  icache_state_t             state_q, state_d;
  word_t                     miss_addr_q, miss_addr_d;
  logic                      fill;

  logic [ITAG_W-1:0]         req_tag, miss_tag;
  logic [IIDX_W-1:0]         req_idx, miss_idx;

  assign req_tag  = imemaddr[31:6];
  assign req_idx  = imemaddr[5:2];
  assign miss_tag = miss_addr_q[31:6];
  assign miss_idx = miss_addr_q[5:2];

  // Combinational lookup; only answers while idle so a pending fill never aliases a hit.
  always_comb begin
    ihit     = imemREN && (state_q == IDLE) && frames_q[req_idx].valid &&
               (frames_q[req_idx].tag == req_tag);
    imemload = frames_q[req_idx].data;
    iREN     = (state_q == FETCH);
    iaddr    = miss_addr_q;
  end

  // Next-state logic: start a fetch on a missed request, return to idle when memory answers.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (imemREN && !ihit) begin
          state_d     = FETCH;
          miss_addr_d = {imemaddr[31:2], 2'b00};
        end
      end
      FETCH: begin
        // The latched address completes even if the datapath changes or drops its request.
        if (!iwait) begin
          state_d = IDLE;
          fill    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and miss-address registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Frame array: reset clears only the valid bits; a fill overwrites the indexed frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: tag and data storage is left unreset; cleared valid bits make their contents irrelevant.
      for (int i = 0; i < ICACHE_FRAMES; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else if (fill) begin
      frames_q[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a table of per-cycle vectors for the cold miss,
// warm hit and conflict flows, plus hand sequences for mid-miss corner cases.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int errors = 0;
  int checks = 0;

  icache dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ren;
    word_t addr;
    logic  wt;
    word_t ld;
    logic  exp_hit;
    logic  exp_iren;
    word_t exp_iaddr;   // compared only when exp_iren = 1
    word_t exp_load;    // compared only when exp_hit = 1
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic drive(input logic ren, input word_t addr, input logic wt, input word_t ld);
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = ld;
    #3;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // idx 0 cold miss with 3 wait cycles, warm hit, conflict with 0x40, refill of 0x0
    vecs[0]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0,  32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0,  32'h0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b0, 1'b1, 32'h0,  32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b0, 1'b1, 32'h0,  32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b0, 1'b1, 32'h0,  32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h8C01_0004, 1'b0, 1'b1, 32'h0,  32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,  32'h8C01_0004};
    vecs[7]  = '{1'b1, 32'h0000_0002, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,  32'h8C01_0004};
    vecs[8]  = '{1'b1, 32'h0000_0040, 1'b0, 32'h2002_0005, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0040, 1'b0, 32'h2002_0005, 1'b0, 1'b1, 32'h40, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,  32'h2002_0005};
    vecs[11] = '{1'b1, 32'h0000_0000, 1'b0, 32'h8C01_0004, 1'b0, 1'b0, 32'h0,  32'h0};
    vecs[12] = '{1'b1, 32'h0000_0000, 1'b0, 32'h8C01_0004, 1'b0, 1'b1, 32'h0,  32'h0};
    vecs[13] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,          1'b1, 1'b0, 32'h0,  32'h8C01_0004};

    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    check("reset_ihit", {31'b0, ihit}, 32'h0);
    check("reset_iREN", {31'b0, iREN}, 32'h0);
    tick();

    // Table-driven flow, one vector per cycle
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ren, vecs[i].addr, vecs[i].wt, vecs[i].ld);
      check($sformatf("vec%0d_ihit", i), {31'b0, ihit}, {31'b0, vecs[i].exp_hit});
      check($sformatf("vec%0d_iREN", i), {31'b0, iREN}, {31'b0, vecs[i].exp_iren});
      if (vecs[i].exp_iren) check($sformatf("vec%0d_iaddr", i), iaddr, vecs[i].exp_iaddr);
      if (vecs[i].exp_hit)  check($sformatf("vec%0d_imemload", i), imemload, vecs[i].exp_load);
      tick();
    end

    // Address change mid-miss: 0x10 fill completes although the datapath moved to 0x20
    drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
    check("chg_miss_ihit", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b0, 32'h0000_0020, 1'b1, 32'h0);
    check("chg_fetch_iREN", {31'b0, iREN}, 32'h1);
    check("chg_fetch_iaddr", iaddr, 32'h10);
    check("chg_fetch_ihit", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0020, 1'b0, 32'hAAAA_0010);
    check("chg_fill_iaddr", iaddr, 32'h10);
    tick();
    drive(1'b1, 32'h0000_0020, 1'b0, 32'hBBBB_0020);
    check("chg_new_miss_ihit", {31'b0, ihit}, 32'h0);
    check("chg_new_miss_iREN", {31'b0, iREN}, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0020, 1'b0, 32'hBBBB_0020);
    check("chg_new_fetch_iaddr", iaddr, 32'h20);
    tick();
    drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
    check("chg_frame4_ihit", {31'b0, ihit}, 32'h1);
    check("chg_frame4_data", imemload, 32'hAAAA_0010);
    tick();
    drive(1'b1, 32'h0000_0020, 1'b1, 32'h0);
    check("chg_frame8_ihit", {31'b0, ihit}, 32'h1);
    check("chg_frame8_data", imemload, 32'hBBBB_0020);
    tick();

    // Idle: no request for 10 cycles with addresses that would hit
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'(i * 8), 1'b0, 32'hDEAD_BEEF);
      check($sformatf("idle%0d_ihit", i), {31'b0, ihit}, 32'h0);
      check($sformatf("idle%0d_iREN", i), {31'b0, iREN}, 32'h0);
      tick();
    end
    drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
    check("idle_after_hit", {31'b0, ihit}, 32'h1);
    check("idle_after_data", imemload, 32'hAAAA_0010);
    tick();

    // Reset mid-miss: fill abandoned, iREN drops, prior hit now misses
    drive(1'b1, 32'h0000_0030, 1'b1, 32'h0);
    check("rstmid_miss_ihit", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0030, 1'b0, 32'h1234_5678);
    check("rstmid_fetch_iREN", {31'b0, iREN}, 32'h1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(1'b0, 32'h0000_0030, 1'b1, 32'h0);
    check("rstmid_after_iREN", {31'b0, iREN}, 32'h0);
    check("rstmid_after_ihit", {31'b0, ihit}, 32'h0);
    drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
    check("rstmid_prior_hit_misses", {31'b0, ihit}, 32'h0);
    tick();
    drive(1'b0, 32'h0000_0030, 1'b1, 32'h0);
    check("rstmid_refetch_iREN", {31'b0, iREN}, 32'h1);
    check("rstmid_refetch_iaddr", iaddr, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed by package constants: ICACHE_FRAMES = 16 frames, one 32-bit word per frame, direct-mapped.
REQ-002 The block SHALL have port `CLK`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `RST`: input, 1 bit, reset; synchronous and active-high.
REQ-004 The block SHALL have port `imemREN`: input, 1 bit, fetch request from the datapath.
REQ-005 The block SHALL have port `imemaddr`: input, 32 bits (`word_t`), fetch address driven by the PC stage.
REQ-006 The block SHALL have port `ihit`: output, 1 bit, requested instruction valid this cycle.
REQ-007 The block SHALL have port `imemload`: output, 32 bits (`word_t`), instruction returned to the datapath.
REQ-008 The block SHALL have port `iREN`: output, 1 bit, read request to the memory controller.
REQ-009 The block SHALL have port `iaddr`: output, 32 bits (`word_t`), word-aligned memory read address.
REQ-010 The block SHALL have port `iwait`: input, 1 bit, memory busy; the read completes in the cycle where `iREN`=1 and `iwait`=0.
REQ-011 The block SHALL have port `iload`: input, 32 bits (`word_t`), memory read data, valid when `iwait`=0.

Function
REQ-012 The address split SHALL be: tag = addr[31:6] (26 bits), index = addr[5:2] (4 bits); addr[1:0] is ignored.
REQ-013 Each frame SHALL hold a valid bit, a 26-bit tag and a 32-bit data word.
REQ-014 Lookup SHALL be combinational: `ihit` = `imemREN` & state==IDLE & valid[idx] & (tag[idx]==addr tag), giving zero-cycle hit latency.
REQ-015 On a hit, `imemload` SHALL equal data[idx]; on a non-hit, `imemload` is don't-care, and the bench checks it only when `ihit`=1.
REQ-016 The FSM SHALL have two states: IDLE and FETCH.
REQ-017 IDLE->FETCH SHALL occur when `imemREN`=1 and the lookup misses; the word-aligned miss address {imemaddr[31:2],2'b00} is latched into `miss_addr` on that edge.
REQ-018 In FETCH, `iREN`=1 and `iaddr`=`miss_addr`; `imemaddr` and `imemREN` are ignored, and `ihit`=0.
REQ-019 FETCH->IDLE SHALL occur on the edge where `iwait`=0; on that edge frame[miss_addr idx] is written with valid=1, the tag of `miss_addr`, and data=`iload`.
REQ-020 The fill SHALL NOT be bypassed to `imemload`: the fetch is re-looked-up in IDLE on the following cycle, so miss latency = (cycles `iwait` high) + 2 cycles.
REQ-021 A changed `imemaddr` or a dropped `imemREN` during FETCH (e.g. a squash) SHALL NOT abort the fill; the latched address completes and the new address is looked up once back in IDLE.
REQ-022 Replacement SHALL be by direct overwrite: a fill evicts any prior occupant of the index with no writeback, since the cache is read-only.
REQ-023 In IDLE, `iREN` SHALL be 0 and `iaddr` SHALL be `miss_addr`; `iaddr` value in IDLE is don't-care.
REQ-024 When `imemREN`=0 in IDLE, the block SHALL keep `ihit`=0, make no state change, and issue no memory request.

Reset
REQ-025 While `RST`=1 at a clock edge, all valid bits SHALL be cleared, the FSM forced to IDLE, and `miss_addr` set to 0; tag and data arrays need not be reset.
REQ-026 After reset, `iREN`=0 and `ihit`=0 until a request arrives.
REQ-027 Reset asserted mid-FETCH SHALL abandon the fill with no frame written, and `iREN` SHALL drop the cycle after the reset edge.

Structure
REQ-028 The shared package `cpu_types_pkg` SHALL hold `word_t`, the constants ITAG_W=26, IIDX_W=4 and ICACHE_FRAMES=16, the struct `icache_frame_t` {valid, tag, data}, and the enum `icache_state_t` {IDLE, FETCH}.
REQ-029 The block SHALL be a single module; no sub-module is natural, and the frame array is an `icache_frame_t` array inside `icache`.

Verification
REQ-030 Cold miss: reset, then `imemREN`=1, addr 0x00000000, `iwait` high for 3 cycles, then low with `iload`=0x8C010004 -> `iREN` high for 4 cycles with `iaddr`=0x0; `ihit`=1 with `imemload`=0x8C010004 one cycle after the fill.
REQ-031 Warm hit: re-read 0x00000002 -> `ihit`=1 in the same cycle, `imemload`=0x8C010004, `iREN`=0.
REQ-032 Conflict: read 0x00000040 (idx 0, tag 1) with fill 0x20020005 -> miss and fill; then 0x00000000 -> miss again and a refill is requested.
REQ-033 Address change mid-miss: miss on 0x00000010, switch `imemaddr` to 0x00000020 during FETCH -> `iaddr` stays 0x10, frame 4 is filled, then 0x20 misses.
REQ-034 Reset mid-miss: assert `RST` in FETCH -> `iREN`=0 on the next cycle; a prior-hit address now misses.
REQ-035 Idle: `imemREN`=0 for 10 cycles with varying `imemaddr` -> `ihit`=0 and `iREN`=0 throughout.
